// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: opcodes, arbiter FSM states and ALU flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ issue-side requesters, the response consumer and the arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*4-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_carry;
    logic                  rsp_overflow;
    logic                  rsp_zero;
    logic                  rsp_negative;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y,
               rsp_carry, rsp_overflow, rsp_zero, rsp_negative, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y,
               rsp_carry, rsp_overflow, rsp_zero, rsp_negative, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational ADD/SUB unit; unknown opcodes give a zero result with carry/overflow cleared.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output alu_flags_t       flags
);
    logic [WIDTH:0] ext;

    always_comb begin
        ext   = '0;
        y     = '0;
        flags = '0;
        case (op)
            OP_ADD: begin
                ext            = {1'b0, a} + {1'b0, b};
                y              = ext[WIDTH-1:0];
                flags.carry    = ext[WIDTH];
                flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry is the inverted borrow: set when a >= b unsigned
                ext            = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                y              = ext[WIDTH-1:0];
                flags.carry    = ext[WIDTH];
                flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
        flags.zero     = (y == '0);
        flags.negative = y[WIDTH-1];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic [IDW-1:0] slot [NREQ];
    logic           found;

    // slot[k] is the requester index examined at search position k
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            logic [IDW:0] raw;
            assign raw      = {1'b0, ptr} + (IDW+1)'(gi);
            assign slot[gi] = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ))
                                                      : raw[IDW-1:0];
        end
    endgenerate

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !found && req[slot[k]]) begin
                found       = 1'b1;
                gnt[slot[k]] = 1'b1;
                gnt_id      = slot[k];
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters with a held valid/ready response.
// Optional per-requester saturating grant counters on perf_grants when ALU_SHARE_ARB_PERF_EN is defined.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0] perf_grants
`endif
);
    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] rsp_y_q;
    alu_flags_t       flags_q;
    logic [IDW-1:0]   rsp_id_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             arb_en;
    logic             accept;
    logic [WIDTH-1:0] alu_y;
    alu_flags_t       alu_flags;

    // rst_n gates the grant so req_ready stays low while reset is asserted
    assign arb_en = (state_q == IDLE) && rst_n;
    assign accept = |gnt;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .y     (alu_y),
        .flags (alu_flags)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = EXEC;
                    rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= '0;
            rsp_y_q  <= '0;
            flags_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                a_q  <= bus.req_a[gnt_id*WIDTH +: WIDTH];
                b_q  <= bus.req_b[gnt_id*WIDTH +: WIDTH];
                op_q <= bus.req_op[gnt_id*4 +: 4];
                id_q <= gnt_id;
            end
            if (state_q == EXEC) begin
                rsp_y_q  <= alu_y;
                flags_q  <= alu_flags;
                rsp_id_q <= id_q;
            end
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.busy         = (state_q != IDLE);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_y        = rsp_y_q;
    assign bus.rsp_carry    = flags_q.carry;
    assign bus.rsp_overflow = flags_q.overflow;
    assign bus.rsp_zero     = flags_q.zero;
    assign bus.rsp_negative = flags_q.negative;

`ifdef ALU_SHARE_ARB_PERF_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_perf
            logic [15:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (gnt[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            assign perf_grants[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a cycle-level transaction model.
module tb_alu_share_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
        int          id;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [NREQ*16-1:0] perf_grants;
`endif

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .perf_grants (perf_grants)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          in_flight;
    int          due;
    exp_t        exp_rsp;
    int          m_ptr;
    int          perf_m [NREQ];
    int          acc_id [$];
    int          acc_cyc [$];
    int          last_acc;
    bit          prev_valid;
    int          rise_cyc;
    logic [31:0] seen_y;
    logic [3:0]  seen_f;
    int          seen_id;
    int          order [5] = '{0, 1, 2, 3, 0};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model_alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op, input int id);
        exp_t   r;
        longint ua, ub, sa, sb, s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.y = '0; r.c = 1'b0; r.o = 1'b0;
        if (op == 4'h0) begin
            s   = ua + ub;
            r.y = s[31:0];
            r.c = (s > 64'sd4294967295);
            s   = sa + sb;
            r.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 4'h1) begin
            r.y = a - b;
            r.c = (ua >= ub);
            s   = sa - sb;
            r.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        r.z  = (r.y == 32'h0);
        r.n  = r.y[31];
        r.id = id;
        return r;
    endfunction

    task automatic model_reset();
        in_flight  = 1'b0;
        m_ptr      = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) perf_m[i] = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        bus.req_valid[i]             = v;
        bus.req_a[i*WIDTH +: WIDTH]  = a;
        bus.req_b[i*WIDTH +: WIDTH]  = b;
        bus.req_op[i*4 +: 4]         = op;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
        check_val({tag, "_valid"}, 64'(bus.rsp_valid), 64'(0));
        check_val({tag, "_busy"},  64'(bus.busy), 64'(0));
        check_val({tag, "_y"},     64'(bus.rsp_y), 64'(0));
        check_val({tag, "_id"},    64'(bus.rsp_id), 64'(0));
        check_val({tag, "_flags"}, 64'({bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero, bus.rsp_negative}), 64'(0));
    endtask

    // One clock: compare at the falling edge, advance the model to what the next rising edge does.
    task automatic run_cycle();
        logic [NREQ-1:0] exp_ready;
        int              w;
        bit              rsp_due;
        @(negedge clk);
        cyc++;
        exp_ready = '0;
        w         = -1;
        last_acc  = -1;
        if (!in_flight) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req_valid[idx]) w = idx;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        rsp_due = in_flight && (cyc >= due);
        check_val("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check_val("busy",      64'(bus.busy), 64'(in_flight));
        check_val("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_due));
        if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rsp_valid;
        if (rsp_due) begin
            check_val("rsp_y",     64'(bus.rsp_y), 64'(exp_rsp.y));
            check_val("rsp_flags", 64'({bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero, bus.rsp_negative}),
                                   64'({exp_rsp.c, exp_rsp.o, exp_rsp.z, exp_rsp.n}));
            check_val("rsp_id",    64'(bus.rsp_id), 64'(exp_rsp.id));
            seen_y  = bus.rsp_y;
            seen_f  = {bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero, bus.rsp_negative};
            seen_id = int'(bus.rsp_id);
        end
`ifdef ALU_SHARE_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++)
            check_val("perf_grants", 64'(perf_grants[i*16 +: 16]), 64'(perf_m[i]));
`endif
        if (w >= 0) begin
            in_flight = 1'b1;
            due       = cyc + 2;
            exp_rsp   = model_alu(bus.req_a[w*WIDTH +: WIDTH], bus.req_b[w*WIDTH +: WIDTH],
                                  bus.req_op[w*4 +: 4], w);
            m_ptr     = (w + 1) % NREQ;
            if (perf_m[w] < 65535) perf_m[w]++;
            acc_id.push_back(w);
            acc_cyc.push_back(cyc);
            last_acc  = w;
        end else if (rsp_due && bus.rsp_ready) begin
            in_flight = 1'b0;
            $display("TXN cycle=%0d id=%0d y=%08h c=%0b o=%0b z=%0b n=%0b", cyc, bus.rsp_id,
                     bus.rsp_y, bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero, bus.rsp_negative);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.rsp_ready = 1'b1;
        set_req(i, 1'b1, a, b, op);
        run_cycle();
        set_req(i, 1'b0, a, b, op);
        repeat (3) run_cycle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return 4'h0;
        if (r < 8) return 4'h1;
        return 4'($urandom_range(2, 15));
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 32'h10 + 32'(i), 32'h3, 4'(i % 2));

        // reset asserted with requests pending
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        rst_n = 1'b1;

        // all requesters held: grant order and issue interval
        bus.rsp_ready = 1'b1;
        acc_id.delete();
        acc_cyc.delete();
        repeat (15) run_cycle();
        bus.req_valid = '0;
        repeat (3) run_cycle();
        check_val("t3_count", 64'(acc_id.size()), 64'(5));
        if (acc_id.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check_val("t3_order", 64'(acc_id[k]), 64'(order[k]));
                if (k > 0) check_val("t3_interval", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(3));
            end
        end

        // signed overflow on ADD
        single_op(0, 32'h7FFF_FFFF, 32'h1, 4'h0);
        check_val("t1_y",       64'(seen_y), 64'h8000_0000);
        check_val("t1_flags",   64'(seen_f), 64'(4'b0101));
        check_val("t1_id",      64'(seen_id), 64'(0));
        check_val("t1_latency", 64'(rise_cyc - acc_cyc[$]), 64'(2));

        // equal SUB: zero with carry (no borrow)
        single_op(2, 32'd5, 32'd5, 4'h1);
        check_val("t2_y",     64'(seen_y), 64'(0));
        check_val("t2_flags", 64'(seen_f), 64'(4'b1010));
        check_val("t2_id",    64'(seen_id), 64'(2));

        // unsupported opcode
        single_op(1, 32'h1234, 32'h1, 4'hF);
        check_val("t6_y",     64'(seen_y), 64'(0));
        check_val("t6_flags", 64'(seen_f), 64'(4'b0010));
        check_val("t6_id",    64'(seen_id), 64'(1));

        // consumer stalls in RESP while another request waits
        bus.rsp_ready = 1'b0;
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'h2, 4'h0);
        run_cycle();
        set_req(3, 1'b0, 32'hFFFF_FFFF, 32'h2, 4'h0);
        set_req(0, 1'b1, 32'h1, 32'h2, 4'h0);
        repeat (6) run_cycle();
        bus.rsp_ready = 1'b1;
        repeat (2) run_cycle();
        set_req(0, 1'b0, 32'h1, 32'h2, 4'h0);
        repeat (3) run_cycle();
        check_val("t4_reaccept", 64'(acc_cyc[$] - acc_cyc[$-1]), 64'(8));
        check_val("t4_y",        64'(seen_y), 64'(3));

        // reset during EXEC, pointer must restart at requester 0
        set_req(2, 1'b1, 32'h9, 32'h4, 4'h1);
        run_cycle();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 32'h20 + 32'(i), 32'h1, 4'h0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_cycle();
        check_val("t5_grant", 64'(acc_id[$]), 64'(0));
        bus.req_valid = '0;
        repeat (3) run_cycle();

        // randomized traffic
        repeat (400) begin
            run_cycle();
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) begin
                    if (last_acc == i) begin
                        if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, rand_operand(), rand_operand(), rand_op());
                        else bus.req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 9) == 0) begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1'b1, rand_operand(), rand_operand(), rand_op());
                end
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
